enc_menu_ctrl: RTL and testbench

- Settings-menu controller for the bicycle helper's rotary-encoder front end.
- Consumes single-cycle CW/CCW step pulses from the encoder decoder and the raw push-key.
- Debounces the key and classifies short and long presses.
- Sequences browse/edit/commit of NUM_ITEMS configuration values, issuing one-cycle write strobes to the downstream config register bank.

---
 rtl/enc_menu_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_enc_menu_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_menu_ctrl.sv
// Settings-menu controller: debounces the push-key, classifies short/long presses
// and sequences browse/edit/commit of config values from rotary-encoder steps.
`timescale 1ns/1ps

module enc_menu_ctrl #(
    parameter int unsigned NUM_ITEMS   = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned VAL_W       = 8,
    parameter int unsigned VAL_MAX     = 99,
    parameter int unsigned DEB_CYC     = 500000,
    parameter int unsigned LONG_CYC    = 50000000,
    parameter int unsigned TIMEOUT_CYC = 250000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_cw,
    input  logic             step_ccw,
    input  logic             key,
    input  logic [VAL_W-1:0] cfg_rdata,
    output logic [IDX_W-1:0] sel_idx,
    output logic [VAL_W-1:0] edit_val,
    output logic             editing,
    output logic             cfg_we,
    output logic [IDX_W-1:0] cfg_addr,
    output logic [VAL_W-1:0] cfg_wdata
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_ITEMS - 1);
    localparam logic [VAL_W-1:0]  VAL_LIMIT = VAL_W'(VAL_MAX);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_BROWSE = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    logic              key_s1;
    logic              key_s2;
    logic              key_db;
    logic              key_db_d;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic short_evt;
    logic long_evt;
    logic cw_ok;
    logic ccw_ok;

    state_t            state;
    state_t            state_nxt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_nxt;
    logic [IDX_W-1:0]  sel_nxt;
    logic [VAL_W-1:0]  val_nxt;
    logic [IDX_W-1:0]  addr_nxt;
    logic [VAL_W-1:0]  wdata_nxt;
    logic              editing_nxt;
    logic              we_nxt;

    // Two-flop synchroniser; idles at the released level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
        end
    end

    // Debounce: accept a new level only after DEB_CYC consecutive differing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_db   <= 1'b1;
            key_db_d <= 1'b1;
            deb_cnt  <= '0;
        end else begin
            key_db_d <= key_db;
            if (key_s2 == key_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                key_db  <= key_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Hold counter saturates at LONG_CYC; it still holds the press length in the release cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (key_db) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_LONG) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign long_evt  = ~key_db & (hold_cnt == HOLD_LAST);
    assign short_evt = key_db & ~key_db_d & (hold_cnt < HOLD_LONG);

    // Steps are dropped when both directions collide or a key event claims the cycle
    assign cw_ok  = step_cw & ~step_ccw & ~short_evt & ~long_evt;
    assign ccw_ok = step_ccw & ~step_cw & ~short_evt & ~long_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_BROWSE;
            tmo_cnt   <= '0;
            sel_idx   <= '0;
            edit_val  <= '0;
            editing   <= 1'b0;
            cfg_we    <= 1'b0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
        end else begin
            state     <= state_nxt;
            tmo_cnt   <= tmo_nxt;
            sel_idx   <= sel_nxt;
            edit_val  <= val_nxt;
            editing   <= editing_nxt;
            cfg_we    <= we_nxt;
            cfg_addr  <= addr_nxt;
            cfg_wdata <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo_cnt;
        sel_nxt   = sel_idx;
        val_nxt   = edit_val;
        addr_nxt  = cfg_addr;
        wdata_nxt = cfg_wdata;

        case (state)
            ST_BROWSE: begin
                if (short_evt) begin
                    val_nxt   = (cfg_rdata > VAL_LIMIT) ? VAL_LIMIT : cfg_rdata;
                    tmo_nxt   = '0;
                    state_nxt = ST_EDIT;
                end else if (cw_ok) begin
                    sel_nxt = (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);
                end else if (ccw_ok) begin
                    sel_nxt = (sel_idx == '0) ? LAST_IDX : sel_idx - IDX_W'(1);
                end
            end

            ST_EDIT: begin
                if (short_evt) begin
                    addr_nxt  = sel_idx;
                    wdata_nxt = edit_val;
                    state_nxt = ST_COMMIT;
                end else if (long_evt) begin
                    state_nxt = ST_BROWSE;
                end else if (cw_ok) begin
                    val_nxt = (edit_val >= VAL_LIMIT) ? VAL_LIMIT : edit_val + VAL_W'(1);
                    tmo_nxt = '0;
                end else if (ccw_ok) begin
                    val_nxt = (edit_val == '0) ? '0 : edit_val - VAL_W'(1);
                    tmo_nxt = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_nxt   = '0;
                    state_nxt = ST_BROWSE;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end

            ST_COMMIT: begin
                state_nxt = ST_BROWSE;
            end

            default: begin
                state_nxt = ST_BROWSE;
            end
        endcase

        editing_nxt = (state_nxt == ST_EDIT);
        we_nxt      = (state_nxt == ST_COMMIT);
    end

endmodule

// File: tb/tb_enc_menu_ctrl.sv
// Directed bench for enc_menu_ctrl with a cycle-level behavioural model of the menu.
`timescale 1ns/1ps

module tb_enc_menu_ctrl;

    localparam int NI   = 4;
    localparam int VMAX = 99;
    localparam int DEB  = 4;
    localparam int LONG = 40;
    localparam int TMO  = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step_cw = 1'b0;
    logic       step_ccw = 1'b0;
    logic       key = 1'b1;
    logic [7:0] cfg_rdata = 8'd0;
    logic [1:0] sel_idx;
    logic [7:0] edit_val;
    logic       editing;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;

    enc_menu_ctrl #(
        .NUM_ITEMS(4), .IDX_W(2), .VAL_W(8), .VAL_MAX(99),
        .DEB_CYC(DEB), .LONG_CYC(LONG), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .step_cw(step_cw), .step_ccw(step_ccw), .key(key),
        .cfg_rdata(cfg_rdata), .sel_idx(sel_idx), .edit_val(edit_val), .editing(editing),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: key level history -> press events -> menu behaviour
    int m_s1 = 1, m_s2 = 1, m_db = 1, m_db_prev = 1, m_run = 0, m_low = 0;
    int m_mode = 0, m_sel = 0, m_val = 0, m_tmo = 0;
    int m_we = 0, m_addr = 0, m_wdata = 0;
    bit e_short, e_long, q_cw, q_ccw;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 = 1; m_s2 = 1; m_db = 1; m_db_prev = 1; m_run = 0; m_low = 0;
            m_mode = 0; m_sel = 0; m_val = 0; m_tmo = 0;
            m_we = 0; m_addr = 0; m_wdata = 0;
        end else begin
            // a press is long once it has lasted LONG debounced-low cycles
            e_long  = (m_db == 0) && (m_low == LONG - 1);
            e_short = (m_db == 1) && (m_db_prev == 0) && (m_low < LONG);
            q_cw    = step_cw && !step_ccw && !e_short && !e_long;
            q_ccw   = step_ccw && !step_cw && !e_short && !e_long;

            m_low = (m_db == 0) ? m_low + 1 : 0;
            m_db_prev = m_db;
            if (m_s2 != m_db) begin
                m_run++;
                if (m_run == DEB) begin
                    m_db = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = key;

            m_we = 0;
            case (m_mode)
                0: begin
                    if (e_short) begin
                        m_val = (cfg_rdata > VMAX) ? VMAX : int'(cfg_rdata);
                        m_tmo = 0;
                        m_mode = 1;
                    end else if (q_cw) m_sel = (m_sel + 1) % NI;
                    else if (q_ccw) m_sel = (m_sel + NI - 1) % NI;
                end
                1: begin
                    if (e_short) begin
                        m_mode = 2; m_we = 1; m_addr = m_sel; m_wdata = m_val;
                    end else if (e_long) m_mode = 0;
                    else if (q_cw || q_ccw) begin
                        m_val = q_cw ? ((m_val < VMAX) ? m_val + 1 : VMAX)
                                     : ((m_val > 0) ? m_val - 1 : 0);
                        m_tmo = 0;
                    end else begin
                        m_tmo++;
                        if (m_tmo == TMO) m_mode = 0;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cmp_sel_idx", sel_idx, m_sel);
        chk("cmp_edit_val", edit_val, m_val);
        chk("cmp_editing", editing, (m_mode == 1) ? 1 : 0);
        chk("cmp_cfg_we", cfg_we, m_we);
        chk("cmp_cfg_addr", cfg_addr, m_addr);
        chk("cmp_cfg_wdata", cfg_wdata, m_wdata);
    end

    int wr_cnt = 0;
    always @(negedge clk) if (cfg_we === 1'b1) wr_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit cw, input bit ccw);
        @(negedge clk);
        step_cw = cw; step_ccw = ccw;
        @(negedge clk);
        step_cw = 1'b0; step_ccw = 1'b0;
    endtask

    task automatic press(input int n);
        @(negedge clk);
        key = 1'b0;
        cyc(n);
        key = 1'b1;
    endtask

    task automatic wait_edit(input logic lvl, input string nm);
        int i = 0;
        while (editing !== lvl && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk(nm, editing, lvl);
    endtask

    task automatic wait_we(input string nm);
        int i = 0;
        while (cfg_we !== 1'b1 && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk(nm, cfg_we, 1);
    endtask

    task automatic check_writes(input int n, input string nm);
        #1;
        chk(nm, wr_cnt, n);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_sel"}, sel_idx, 0);
        chk({nm, "_val"}, edit_val, 0);
        chk({nm, "_editing"}, editing, 0);
        chk({nm, "_we"}, cfg_we, 0);
        chk({nm, "_addr"}, cfg_addr, 0);
        chk({nm, "_wdata"}, cfg_wdata, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_sel[5];
        exp_sel = '{1, 2, 3, 0, 1};

        #1 rst = 1'b0;
        cyc(3);
        check_reset_outputs("reset");
        @(negedge clk) rst = 1'b1;
        cyc(2);

        // browse wrap
        for (int i = 0; i < 5; i++) begin
            pulse(1, 0);
            chk("browse_cw", sel_idx, exp_sel[i]);
            chk("browse_not_editing", editing, 0);
        end
        check_writes(0, "browse_no_write");
        pulse(1, 0);
        chk("browse_to_2", sel_idx, 2);

        // edit 50 -> 52 and commit
        cfg_rdata = 8'd50;
        press(10);
        wait_edit(1, "enter_edit_50");
        chk("entry_val_50", edit_val, 50);
        for (int i = 0; i < 3; i++) pulse(1, 0);
        pulse(0, 1);
        chk("edit_val_52", edit_val, 52);
        press(10);
        wait_we("commit_52_we");
        chk("commit_addr", cfg_addr, 2);
        chk("commit_wdata_52", cfg_wdata, 52);
        @(negedge clk);
        chk("commit_we_drop", cfg_we, 0);
        chk("commit_back_browse", editing, 0);
        check_writes(1, "one_write");
        cyc(2);

        // low saturation
        cfg_rdata = 8'd1;
        press(10);
        wait_edit(1, "enter_edit_1");
        for (int i = 0; i < 3; i++) pulse(0, 1);
        chk("sat_low", edit_val, 0);
        press(10);
        wait_we("commit_0_we");
        chk("commit_wdata_0", cfg_wdata, 0);
        cyc(2);

        // high saturation
        cfg_rdata = 8'd97;
        press(10);
        wait_edit(1, "enter_edit_97");
        chk("entry_val_97", edit_val, 97);
        for (int i = 0; i < 5; i++) pulse(1, 0);
        chk("sat_high", edit_val, 99);
        press(10);
        wait_we("commit_99_we");
        chk("commit_wdata_99", cfg_wdata, 99);
        cyc(2);

        // clamp on entry, then bounce followed by long press aborts
        cfg_rdata = 8'd120;
        press(10);
        wait_edit(1, "enter_edit_120");
        chk("entry_clamp", edit_val, 99);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            key = (i % 2 == 0) ? 1'b0 : 1'b1;
        end
        chk("bounce_still_editing", editing, 1);
        @(negedge clk);
        key = 1'b0;
        cyc(50);
        chk("long_abort", editing, 0);
        chk("long_abort_sel", sel_idx, 2);
        key = 1'b1;
        cyc(20);
        chk("no_short_after_long", editing, 0);
        check_writes(3, "abort_no_write");

        // idle timeout
        cfg_rdata = 8'd10;
        press(10);
        wait_edit(1, "enter_edit_tmo");
        cyc(99);
        chk("tmo_not_yet", editing, 1);
        cyc(1);
        chk("tmo_expired", editing, 0);
        check_writes(3, "tmo_no_write");

        // step near the end restarts the timeout
        press(10);
        wait_edit(1, "enter_edit_tmo2");
        cyc(89);
        step_cw = 1'b1;
        @(negedge clk);
        step_cw = 1'b0;
        chk("tmo_step_val", edit_val, 11);
        cyc(99);
        chk("tmo_restart_not_yet", editing, 1);
        cyc(1);
        chk("tmo_restart_expired", editing, 0);
        check_writes(3, "tmo2_no_write");

        // simultaneous steps ignored in both states
        pulse(1, 1);
        chk("both_browse", sel_idx, 2);
        cfg_rdata = 8'd30;
        press(10);
        wait_edit(1, "enter_edit_30");
        pulse(1, 1);
        chk("both_edit", edit_val, 30);
        pulse(1, 0);
        chk("edit_31", edit_val, 31);

        // asynchronous reset mid-edit
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        cyc(2);
        rst = 1'b1;
        cyc(3);
        chk("post_rst_editing", editing, 0);
        check_writes(3, "rst_no_write");
        pulse(0, 1);
        chk("browse_ccw_wrap", sel_idx, 3);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
